// File: rtl/display_scan_driver_if.sv
// Load bus for display_scan_driver: a 16-bit value offered on a valid/ready
// handshake. The master side offers data; the slave side (the driver)
// accepts it into its shadow register.
interface display_scan_driver_if;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_ready;

    modport master (output load_data, output load_valid, input load_ready);
    modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/display_scan_driver.sv
// display_scan_driver: upstream feeder for a 4-digit 7-segment multiplexer.
// A value accepted over the load bus waits in a shadow register and is
// committed to the digit outputs only on the scan-frame wrap (slot 3 -> 0),
// so a frame never shows a mix of old and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits are blanked: slot 3 is dark when
//   digit_4 is 0, slot 2 when digits 4..3 are 0, and slot 1 when digits 4..2
//   are 0. Slot 0 always stays lit. When undefined there is no blanking logic.
module display_scan_driver #(
    parameter int PRESCALE = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    display_scan_driver_if.slave load_if,
    input  logic                 display_enable,
    output logic [3:0]           digit_1,
    output logic [3:0]           digit_2,
    output logic [3:0]           digit_3,
    output logic [3:0]           digit_4,
    output logic [1:0]           refresh_count,
    output logic [3:0]           anode,
    output logic                 frame_start
);

    localparam int CNT_W = $clog2(PRESCALE + 1);

    logic [CNT_W-1:0] prescaler_r;
    logic [1:0]       refresh_count_r;
    logic [3:0]       anode_r;
    logic             frame_start_r;
    logic             pending_r;
    logic [15:0]      shadow_r;
    logic [15:0]      digits_r;

    logic             tick_s;
    logic             wrap_s;
    logic             accept_s;
    logic             commit_s;
    logic [1:0]       slot_next_s;
    logic [3:0]       lit_s;
    logic [3:0]       anode_next_s;

`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0]      digits_next_s;

    // Slots that stay lit for a given committed value; slot 0 is never blanked.
    function automatic logic [3:0] lit_mask(input logic [15:0] value);
        logic [3:0] mask;
        mask[0] = 1'b1;
        mask[1] = |value[15:4];
        mask[2] = |value[15:8];
        mask[3] = |value[15:12];
        return mask;
    endfunction
`endif

    // Slot timing, handshake qualification and next anode pattern.
    always_comb begin
        tick_s      = (prescaler_r == CNT_W'(PRESCALE - 1));
        wrap_s      = tick_s && (refresh_count_r == 2'd3);
        // Accept and commit are exclusive: accept needs pending low, commit
        // needs it high, so a value accepted on a wrap waits a full frame.
        accept_s    = load_if.load_valid && !pending_r;
        commit_s    = wrap_s && pending_r;
        slot_next_s = tick_s ? (refresh_count_r + 2'd1) : refresh_count_r;
`ifdef LEADING_ZERO_BLANK_EN
        // Blank on the digits that will be shown alongside the new anode.
        digits_next_s = commit_s ? shadow_r : digits_r;
        lit_s         = lit_mask(digits_next_s);
`else
        lit_s         = 4'b1111;
`endif
        anode_next_s = display_enable ? ~((4'b0001 << slot_next_s) & lit_s)
                                      : 4'b1111;
    end

    // Prescaler: counts 0..PRESCALE-1 and wraps, one tick per digit slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            prescaler_r <= {CNT_W{1'b0}};
        end else begin
            prescaler_r <= prescaler_r + CNT_W'(1);
        end
    end

    // Scan slot, anode enables and frame_start pulse, all updated together.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_count_r <= 2'd0;
            anode_r         <= 4'b1110;
            frame_start_r   <= 1'b0;
        end else begin
            refresh_count_r <= slot_next_s;
            anode_r         <= anode_next_s;
            frame_start_r   <= wrap_s;
        end
    end

    // Shadow register and pending flag; a reset discards an uncommitted value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r  <= 16'h0000;
            pending_r <= 1'b0;
        end else if (commit_s) begin
            pending_r <= 1'b0;
        end else if (accept_s) begin
            shadow_r  <= load_if.load_data;
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Committed digits change only on the frame wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_r <= 16'h0000;
        end else if (commit_s) begin
            digits_r <= shadow_r;
        end else begin
            digits_r <= digits_r;
        end
    end

    assign load_if.load_ready = ~pending_r;
    assign digit_4       = digits_r[15:12];
    assign digit_3       = digits_r[11:8];
    assign digit_2       = digits_r[7:4];
    assign digit_1       = digits_r[3:0];
    assign refresh_count = refresh_count_r;
    assign anode         = anode_r;
    assign frame_start   = frame_start_r;

endmodule

// File: tb/tb_display_scan_driver.sv
// Testbench for display_scan_driver with PRESCALE = 4. A cycle model tracks
// the expected scan slot, anode pattern, frame pulse and pending state; each
// accepted load is pushed to a scoreboard queue and popped when the model
// reaches a frame wrap, giving the value the digits must show.
module tb_display_scan_driver;

    localparam int PRE   = 4;
    localparam int FRAME = 4 * PRE;

    logic       clk;
    logic       reset;
    logic       display_enable;
    logic [3:0] digit_1, digit_2, digit_3, digit_4;
    logic [1:0] refresh_count;
    logic [3:0] anode;
    logic       frame_start;

    display_scan_driver_if bus ();

    display_scan_driver #(.PRESCALE(PRE)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_if        (bus),
        .display_enable (display_enable),
        .digit_1        (digit_1),
        .digit_2        (digit_2),
        .digit_3        (digit_3),
        .digit_4        (digit_4),
        .refresh_count  (refresh_count),
        .anode          (anode),
        .frame_start    (frame_start)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          cyc = 0;
    bit          mp = 1'b0;
    int          acc_cnt = 0;
    logic [15:0] exp_disp = 16'h0000;
    logic [15:0] exp_q [$];
    logic [3:0]  anode_exp = 4'b1110;
    bit          frame_exp = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] slot_onehot(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    function automatic logic [3:0] lit_of(input logic [15:0] v);
`ifdef LEADING_ZERO_BLANK_EN
        logic [3:0] m;
        m[0] = 1'b1;
        m[1] = (v[15:4]  != 12'h000);
        m[2] = (v[15:8]  != 8'h00);
        m[3] = (v[15:12] != 4'h0);
        return m;
`else
        return (v == v) ? 4'b1111 : 4'b1111;
`endif
    endfunction

    function automatic logic [1:0] exp_rc(input int c);
        return 2'((c / PRE) % 4);
    endfunction

    // Cycle model and scoreboard push/pop.
    always @(posedge clk) begin
        if (reset) begin
            cyc       <= 0;
            mp        <= 1'b0;
            exp_disp  <= 16'h0000;
            anode_exp <= 4'b1110;
            frame_exp <= 1'b0;
            exp_q.delete();
        end else begin
            cyc       <= cyc + 1;
            frame_exp <= ((cyc % FRAME) == FRAME - 1);
            anode_exp <= display_enable
                ? ~(slot_onehot(((cyc + 1) / PRE) % 4) &
                    lit_of((((cyc % FRAME) == FRAME - 1) && mp) ? exp_q[0] : exp_disp))
                : 4'b1111;
            if (((cyc % FRAME) == FRAME - 1) && mp) begin
                exp_disp <= exp_q.pop_front();
                mp       <= 1'b0;
            end else if (bus.load_valid && !mp) begin
                exp_q.push_back(bus.load_data);
                mp      <= 1'b1;
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'hDEAD;
        step(); step(); step();
        n_cmp++; if (anode !== 4'b1110) begin n_err++; $display("FAIL reset_anode: got %b expected %b", anode, 4'b1110); end
        n_cmp++; if (refresh_count !== 2'd0) begin n_err++; $display("FAIL reset_refresh: got %0d expected 0", refresh_count); end
        n_cmp++; if ({digit_4, digit_3, digit_2, digit_1} !== 16'h0000) begin n_err++; $display("FAIL reset_digits: got %h expected 0000", {digit_4, digit_3, digit_2, digit_1}); end
        n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bus.load_ready); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %b expected 0", frame_start); end
        bus.load_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int pulses = 0;
        for (int i = 0; i < 3 * FRAME + 2; i++) begin
            step();
            n_cmp++; if (refresh_count !== exp_rc(cyc)) begin n_err++; $display("FAIL scan_refresh: got %0d expected %0d", refresh_count, exp_rc(cyc)); end
            n_cmp++; if (anode !== anode_exp) begin n_err++; $display("FAIL scan_anode: got %b expected %b", anode, anode_exp); end
            n_cmp++; if (frame_start !== frame_exp) begin n_err++; $display("FAIL scan_frame: got %b expected %b", frame_start, frame_exp); end
            if (frame_start === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL scan_pulse_count: got %0d expected 3", pulses); end
    endtask

    task automatic test_commit();
        bit found = 1'b0;
        int guard = 0;
        while (exp_rc(cyc) != 2'd1 && guard < 4 * FRAME) begin step(); guard++; end
        n_cmp++; if (exp_rc(cyc) != 2'd1) begin n_err++; $display("FAIL commit_align_timeout: got slot %0d expected 1", exp_rc(cyc)); end
        bus.load_data  = 16'hBEEF;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;
        n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL commit_ready_low: got %b expected 0", bus.load_ready); end
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            n_cmp++; if ({digit_4, digit_3, digit_2, digit_1} !== exp_disp) begin n_err++; $display("FAIL commit_digits: got %h expected %h", {digit_4, digit_3, digit_2, digit_1}, exp_disp); end
            n_cmp++; if (bus.load_ready !== !mp) begin n_err++; $display("FAIL commit_ready: got %b expected %b", bus.load_ready, !mp); end
            if ({digit_4, digit_3, digit_2, digit_1} === 16'hBEEF) begin
                found = 1'b1;
                n_cmp++; if (refresh_count !== 2'd0) begin n_err++; $display("FAIL commit_at_wrap: got slot %0d expected 0", refresh_count); end
                n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL commit_frame: got %b expected 1", frame_start); end
                n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL commit_ready_back: got %b expected 1", bus.load_ready); end
            end else begin
                step();
            end
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL commit_timeout: got %h expected beef", {digit_4, digit_3, digit_2, digit_1}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] obs [$];
        logic [15:0] prev;
        int base;
        int guard;
        prev = {digit_4, digit_3, digit_2, digit_1};
        base = acc_cnt;
        bus.load_data  = 16'h1234;
        bus.load_valid = 1'b1;
        for (int phase = 1; phase <= 2; phase++) begin
            guard = 0;
            while (acc_cnt < base + phase && guard < 3 * FRAME) begin
                step(); guard++;
                n_cmp++; if (bus.load_ready !== !mp) begin n_err++; $display("FAIL b2b_ready: got %b expected %b", bus.load_ready, !mp); end
                n_cmp++; if ({digit_4, digit_3, digit_2, digit_1} !== exp_disp) begin n_err++; $display("FAIL b2b_digits: got %h expected %h", {digit_4, digit_3, digit_2, digit_1}, exp_disp); end
                if ({digit_4, digit_3, digit_2, digit_1} !== prev) begin
                    prev = {digit_4, digit_3, digit_2, digit_1};
                    obs.push_back(prev);
                end
            end
            n_cmp++; if (acc_cnt < base + phase) begin n_err++; $display("FAIL b2b_accept_timeout: got %0d accepts expected %0d", acc_cnt - base, phase); end
            bus.load_data = 16'h5678;
        end
        bus.load_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            n_cmp++; if ({digit_4, digit_3, digit_2, digit_1} !== exp_disp) begin n_err++; $display("FAIL b2b_digits: got %h expected %h", {digit_4, digit_3, digit_2, digit_1}, exp_disp); end
            if ({digit_4, digit_3, digit_2, digit_1} !== prev) begin
                prev = {digit_4, digit_3, digit_2, digit_1};
                obs.push_back(prev);
            end
        end
        n_cmp++; if (obs.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d changes expected 2", obs.size()); end
        if (obs.size() == 2) begin
            n_cmp++; if (obs[0] !== 16'h1234) begin n_err++; $display("FAIL b2b_first: got %h expected 1234", obs[0]); end
            n_cmp++; if (obs[1] !== 16'h5678) begin n_err++; $display("FAIL b2b_second: got %h expected 5678", obs[1]); end
        end
    endtask

    task automatic test_disable();
        display_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (anode !== 4'b1111) begin n_err++; $display("FAIL disable_anode: got %b expected 1111", anode); end
            n_cmp++; if (refresh_count !== exp_rc(cyc)) begin n_err++; $display("FAIL disable_refresh: got %0d expected %0d", refresh_count, exp_rc(cyc)); end
        end
        display_enable = 1'b1;
        step();
        n_cmp++; if (anode !== anode_exp) begin n_err++; $display("FAIL enable_anode: got %b expected %b", anode, anode_exp); end
    endtask

    task automatic test_reset_pending();
        int guard = 0;
        while ((cyc % FRAME) != 1 && guard < 2 * FRAME) begin step(); guard++; end
        bus.load_data  = 16'hAAAA;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        step();
        n_cmp++; if (bus.load_ready !== 1'b0) begin n_err++; $display("FAIL pend_ready: got %b expected 0", bus.load_ready); end
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++; if ({digit_4, digit_3, digit_2, digit_1} !== 16'h0000) begin n_err++; $display("FAIL pend_reset_digits: got %h expected 0000", {digit_4, digit_3, digit_2, digit_1}); end
        n_cmp++; if (bus.load_ready !== 1'b1) begin n_err++; $display("FAIL pend_reset_ready: got %b expected 1", bus.load_ready); end
        n_cmp++; if (refresh_count !== 2'd0) begin n_err++; $display("FAIL pend_reset_slot: got %0d expected 0", refresh_count); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            n_cmp++; if ({digit_4, digit_3, digit_2, digit_1} !== 16'h0000) begin n_err++; $display("FAIL pend_discard: got %h expected 0000", {digit_4, digit_3, digit_2, digit_1}); end
        end
        n_cmp++; if (refresh_count !== exp_rc(cyc)) begin n_err++; $display("FAIL pend_scan: got %0d expected %0d", refresh_count, exp_rc(cyc)); end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_blank();
        logic [15:0] vals [3];
        logic [3:0]  lits [3];
        logic [3:0]  want;
        int guard;
        vals[0] = 16'h0005; lits[0] = 4'b0001;
        vals[1] = 16'h0000; lits[1] = 4'b0001;
        vals[2] = 16'h1000; lits[2] = 4'b1111;
        for (int v = 0; v < 3; v++) begin
            bus.load_data  = vals[v];
            bus.load_valid = 1'b1;
            step();
            bus.load_valid = 1'b0;
            guard = 0;
            while ((mp || exp_disp !== vals[v]) && guard < 3 * FRAME) begin step(); guard++; end
            n_cmp++; if ({digit_4, digit_3, digit_2, digit_1} !== vals[v]) begin n_err++; $display("FAIL blank_commit: got %h expected %h", {digit_4, digit_3, digit_2, digit_1}, vals[v]); end
            for (int i = 0; i < FRAME; i++) begin
                want = ~(slot_onehot(exp_rc(cyc)) & lits[v]);
                n_cmp++; if (anode !== want) begin n_err++; $display("FAIL blank_anode: value %h slot %0d got %b expected %b", vals[v], exp_rc(cyc), anode, want); end
                step();
            end
        end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        display_enable = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;
        @(negedge clk);
        test_reset();
        test_scan();
        test_commit();
        test_back_to_back();
        test_disable();
        test_reset_pending();
`ifdef LEADING_ZERO_BLANK_EN
        test_blank();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
